// File: rtl/ysyx_23060240_lsu.sv
// Load/store unit: takes one EXU request at a time, runs one aligned word
// transaction on the valid/ready data bus, and returns extended load data to WBU.
module ysyx_23060240_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_ren,
  input  logic              req_wen,
  input  logic [2:0]        req_rd_ctrl,
  input  logic [1:0]        req_wr_ctrl,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rerr,
  output logic [1:0]        dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends combinationally on ready, and payload is held
  // stable while valid is high and ready is low.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                ren_q, ren_d;
  logic                wen_q, wen_d;
  logic [2:0]          rd_ctrl_q, rd_ctrl_d;
  logic [1:0]          wr_ctrl_q, wr_ctrl_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                req_illegal;
  logic [31:0]         lane;
  logic [31:0]         load_data;
  logic [3:0]          strb;
  logic                in_req;

  always_comb begin
    req_illegal = 1'b0;
    if (req_ren == req_wen) begin
      req_illegal = 1'b1;
    end else if (req_ren) begin
      case (req_rd_ctrl)
        3'b000, 3'b100: req_illegal = 1'b0;
        3'b001, 3'b101: req_illegal = req_addr[0];
        3'b010:         req_illegal = |req_addr[1:0];
        default:        req_illegal = 1'b1;
      endcase
    end else begin
      case (req_wr_ctrl)
        2'b00:   req_illegal = 1'b0;
        2'b01:   req_illegal = req_addr[0];
        2'b10:   req_illegal = |req_addr[1:0];
        default: req_illegal = 1'b1;
      endcase
    end
  end

  assign lane = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (rd_ctrl_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b010:  load_data = mem_rdata;
      3'b100:  load_data = {24'd0, lane[7:0]};
      3'b101:  load_data = {16'd0, lane[15:0]};
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    case (wr_ctrl_q)
      2'b00:   strb = 4'b0001 << addr_q[1:0];
      2'b01:   strb = 4'b0011 << addr_q[1:0];
      2'b10:   strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    rd_ctrl_d = rd_ctrl_q;
    wr_ctrl_d = wr_ctrl_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ren_d     = req_ren;
          wen_d     = req_wen;
          rd_ctrl_d = req_rd_ctrl;
          wr_ctrl_d = req_wr_ctrl;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          cnt_d     = '0;
          rdata_d   = 32'd0;
          err_d     = req_illegal;
          state_d   = req_illegal ? RESP : REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response arriving on the last allowed cycle still beats the timeout.
        if (mem_rvalid) begin
          err_d   = mem_rerr;
          rdata_d = (ren_q && !mem_rerr) ? load_data : 32'd0;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      rd_ctrl_q <= 3'd0;
      wr_ctrl_q <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      cnt_q     <= '0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      rd_ctrl_q <= rd_ctrl_d;
      wr_ctrl_q <= wr_ctrl_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign in_req      = (state_q == REQ);
  assign req_ready   = (state_q == IDLE);
  assign mem_valid   = in_req;
  assign mem_addr    = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wen     = in_req & wen_q;
  assign mem_wstrb   = (in_req && wen_q) ? strb : 4'b0000;
  assign mem_wdata   = (in_req && wen_q) ? (wdata_q << {addr_q[1:0], 3'b000}) : 32'd0;
  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = resp_valid ? rdata_q : 32'd0;
  assign resp_err    = resp_valid & err_q;
  assign dbg_state_o = state_q;

endmodule
